// File: rtl/rf_pkg.sv
// Shared types and constants for the pipeline register file.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_state_e;

  // Index width for a file of nregs entries.
  function automatic int rf_index_width(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: write-to-read bypass and producer-ready indication.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = 5
) (
  input  logic            idle,
  input  logic [AW-1:0]   index,
  input  logic [XLEN-1:0] arr_data,
  input  logic            busy_bit,
  input  logic            wb0_en,
  input  logic [AW-1:0]   wb0_rd,
  input  logic [XLEN-1:0] wb0_data,
  input  logic            wb0_clr,
  input  logic            wb1_en,
  input  logic [AW-1:0]   wb1_rd,
  input  logic [XLEN-1:0] wb1_data,
  input  logic            wb1_clr,
  output logic [XLEN-1:0] data,
  output logic            ready
);

  logic hit0;
  logic hit1;
  logic is_zero;

  // Bypass only applies while the file accepts writes.
  assign hit0    = idle && wb0_en && (wb0_rd == index);
  assign hit1    = idle && wb1_en && (wb1_rd == index);
  assign is_zero = (index == '0);

  // Data select: x0, then wb0, then wb1, then the stored value.
  always_comb begin
    data = arr_data;
    if (is_zero)   data = '0;
    else if (hit0) data = wb0_data;
    else if (hit1) data = wb1_data;
  end

  // A same-cycle write that retires the producer makes the value usable now.
  always_comb begin
    ready = 1'b0;
    if (!idle)        ready = 1'b0;
    else if (is_zero) ready = 1'b1;
    else              ready = !busy_bit || (hit0 && wb0_clr) || (hit1 && wb1_clr);
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with dual write, bypass, busy scoreboard
// and a clear engine that zeroes the array after reset or on request.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   RF_IDLE  | normal operation: writes, issue marking, bypass enabled
//   RF_CLEAR | zeroing reg[1..NREGS-1], one per cycle; all requests ignored
module regfile_sb
  import rf_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NREAD = 2,
  localparam int AW    = rf_index_width(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  output logic                  clear_busy,
  input  logic [NREAD*AW-1:0]   rs_index,
  output logic [NREAD*XLEN-1:0] rs_data,
  output logic [NREAD-1:0]      rs_ready,
  input  logic                  wb0_en,
  input  logic [AW-1:0]         wb0_rd,
  input  logic [XLEN-1:0]       wb0_data,
  input  logic                  wb0_clr,
  input  logic                  wb1_en,
  input  logic [AW-1:0]         wb1_rd,
  input  logic [XLEN-1:0]       wb1_data,
  input  logic                  wb1_clr,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_rd
);

  rf_state_e       state, state_nxt;
  logic [AW-1:0]   clr_idx, idx_nxt;
  logic [NREGS-1:0] busy, busy_nxt;
  logic [XLEN-1:0] mem [NREGS];
  logic            idle;

  assign idle       = (state == RF_IDLE);
  assign clear_busy = (state == RF_CLEAR);

  // FSM, clear index and scoreboard registers; reset starts a full clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RF_CLEAR;
      clr_idx <= AW'(1);
      busy    <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= idx_nxt;
      busy    <= busy_nxt;
    end
  end

  // Next state, clear index and scoreboard; a new issue overrides a retiring write.
  always_comb begin
    state_nxt = state;
    idx_nxt   = clr_idx;
    busy_nxt  = busy;
    case (state)
      RF_IDLE: begin
        if (wb0_en && wb0_clr) busy_nxt[wb0_rd] = 1'b0;
        if (wb1_en && wb1_clr) busy_nxt[wb1_rd] = 1'b0;
        if (iss_en)            busy_nxt[iss_rd] = 1'b1;
        if (clear_req) begin
          state_nxt = RF_CLEAR;
          idx_nxt   = AW'(1);
          busy_nxt  = '0;
        end
      end
      RF_CLEAR: begin
        idx_nxt = clr_idx + AW'(1);
        if (clr_idx == AW'(NREGS - 1)) begin
          state_nxt = RF_IDLE;
          busy_nxt  = '0;
        end
      end
      default: state_nxt = RF_IDLE;
    endcase
    busy_nxt[0] = 1'b0;
  end

  // Array write: clear engine, else wb1 then wb0 so wb0 wins a collision.
  always_ff @(posedge clk) begin
    if (state == RF_CLEAR) begin
      mem[clr_idx] <= '0;
    end else begin
      if (wb1_en && (wb1_rd != '0)) mem[wb1_rd] <= wb1_data;
      if (wb0_en && (wb0_rd != '0)) mem[wb0_rd] <= wb0_data;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] idx;
    assign idx = rs_index[i*AW +: AW];

    rf_read_port #(.XLEN(XLEN), .AW(AW)) u_port (
      .idle     (idle),
      .index    (idx),
      .arr_data (mem[idx]),
      .busy_bit (busy[idx]),
      .wb0_en   (wb0_en),
      .wb0_rd   (wb0_rd),
      .wb0_data (wb0_data),
      .wb0_clr  (wb0_clr),
      .wb1_en   (wb1_en),
      .wb1_rd   (wb1_rd),
      .wb1_data (wb1_data),
      .wb1_clr  (wb1_clr),
      .data     (rs_data[i*XLEN +: XLEN]),
      .ready    (rs_ready[i])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (default 32x32, two read ports).
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_req;
  logic        clear_busy;
  logic [9:0]  rs_index;
  logic [63:0] rs_data;
  logic [1:0]  rs_ready;
  logic        wb0_en, wb0_clr, wb1_en, wb1_clr, iss_en;
  logic [4:0]  wb0_rd, wb1_rd, iss_rd;
  logic [31:0] wb0_data, wb1_data;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        ready;
  } exp_t;

  typedef struct {
    logic        w0e; logic [4:0] w0r; logic [31:0] w0d; logic w0c;
    logic        w1e; logic [4:0] w1r; logic [31:0] w1d; logic w1c;
    logic        ie;  logic [4:0] ir;
    logic [4:0]  r0;  logic [4:0] r1;
    logic [31:0] d0;  logic e0;
    logic [31:0] d1;  logic e1;
  } step_t;

  exp_t exp_q[$];

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .clear_busy(clear_busy),
    .rs_index(rs_index), .rs_data(rs_data), .rs_ready(rs_ready),
    .wb0_en(wb0_en), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_clr(wb0_clr),
    .wb1_en(wb1_en), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_clr(wb1_clr),
    .iss_en(iss_en), .iss_rd(iss_rd)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(
    input logic w0e, input logic [4:0] w0r, input logic [31:0] w0d, input logic w0c,
    input logic w1e, input logic [4:0] w1r, input logic [31:0] w1d, input logic w1c,
    input logic ie, input logic [4:0] ir, input logic [4:0] r0, input logic [4:0] r1,
    input logic [31:0] d0, input logic e0, input logic [31:0] d1, input logic e1);
    step_t s;
    s.w0e = w0e; s.w0r = w0r; s.w0d = w0d; s.w0c = w0c;
    s.w1e = w1e; s.w1r = w1r; s.w1d = w1d; s.w1c = w1c;
    s.ie = ie; s.ir = ir; s.r0 = r0; s.r1 = r1;
    s.d0 = d0; s.e0 = e0; s.d1 = d1; s.e1 = e1;
    return s;
  endfunction

  // Drive one cycle of stimulus and queue the expected read results.
  task automatic apply(input step_t s);
    clear_req = 1'b0;
    wb0_en = s.w0e; wb0_rd = s.w0r; wb0_data = s.w0d; wb0_clr = s.w0c;
    wb1_en = s.w1e; wb1_rd = s.w1r; wb1_data = s.w1d; wb1_clr = s.w1c;
    iss_en = s.ie;  iss_rd = s.ir;
    rs_index = {s.r1, s.r0};
    exp_q.push_back('{port: 0, data: s.d0, ready: s.e0});
    exp_q.push_back('{port: 1, data: s.d1, ready: s.e1});
  endtask

  task automatic quiet();
    clear_req = 1'b0;
    wb0_en = 1'b0; wb0_rd = '0; wb0_data = '0; wb0_clr = 1'b0;
    wb1_en = 1'b0; wb1_rd = '0; wb1_data = '0; wb1_clr = 1'b0;
    iss_en = 1'b0; iss_rd = '0;
  endtask

  task automatic test_reset();
    int cnt;
    exp_t e;
    if (clear_busy !== 1'b1) begin
      miscompares++; $display("FAIL reset_clear_busy: got %b want 1", clear_busy);
    end
    vectors++;
    if (rs_ready !== 2'b00) begin
      miscompares++; $display("FAIL reset_rs_ready: got %b want 00", rs_ready);
    end
    vectors++;
    rst_n = 1'b1;
    wb0_en = 1'b1; wb0_rd = 5'd6; wb0_data = 32'hAA; wb0_clr = 1'b0;
    iss_en = 1'b1; iss_rd = 5'd6;
    rs_index = {5'd6, 5'd6};
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      #4;
      if (!clear_busy) break;
      cnt++;
      if (cnt == 1) begin
        vectors++;
        if (rs_ready !== 2'b00) begin
          miscompares++; $display("FAIL clear_rs_ready: got %b want 00", rs_ready);
        end
      end
      @(negedge clk);
    end
    quiet();
    vectors++;
    if (cnt != 31) begin
      miscompares++; $display("FAIL reset_clear_cycles: got %0d want 31", cnt);
    end
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      apply(mk(0,0,0,0, 0,0,0,0, 0,0, 5'(i), 5'(31-i), 0,1, 0,1));
      #4;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (rs_data[e.port*32 +: 32] !== e.data || rs_ready[e.port] !== e.ready) begin
          miscompares++;
          $display("FAIL post_clear reg%0d port%0d: got data=%h ready=%b want data=%h ready=%b",
                   i, e.port, rs_data[e.port*32 +: 32], rs_ready[e.port], e.data, e.ready);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_write_bypass();
    step_t st[$];
    exp_t e;
    st.push_back(mk(1,5,32'hDEADBEEF,0, 0,0,0,0, 0,0, 5,0, 32'hDEADBEEF,1, 0,1));
    st.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 5,5, 32'hDEADBEEF,1, 32'hDEADBEEF,1));
    st.push_back(mk(0,0,0,0, 1,8,32'h33,0, 0,0, 8,5, 32'h33,1, 32'hDEADBEEF,1));
    st.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 8,8, 32'h33,1, 32'h33,1));
    foreach (st[k]) begin
      apply(st[k]);
      #4;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (rs_data[e.port*32 +: 32] !== e.data || rs_ready[e.port] !== e.ready) begin
          miscompares++;
          $display("FAIL bypass step%0d port%0d: got data=%h ready=%b want data=%h ready=%b",
                   k, e.port, rs_data[e.port*32 +: 32], rs_ready[e.port], e.data, e.ready);
        end
      end
      @(negedge clk);
    end
    quiet();
  endtask

  task automatic test_collision();
    step_t st[$];
    exp_t e;
    st.push_back(mk(1,7,32'h11,0, 1,7,32'h22,0, 0,0, 7,7, 32'h11,1, 32'h11,1));
    st.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 7,7, 32'h11,1, 32'h11,1));
    st.push_back(mk(1,0,32'hFF,0, 1,0,32'hEE,0, 1,0, 0,0, 0,1, 0,1));
    st.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 0,7, 0,1, 32'h11,1));
    foreach (st[k]) begin
      apply(st[k]);
      #4;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (rs_data[e.port*32 +: 32] !== e.data || rs_ready[e.port] !== e.ready) begin
          miscompares++;
          $display("FAIL collision step%0d port%0d: got data=%h ready=%b want data=%h ready=%b",
                   k, e.port, rs_data[e.port*32 +: 32], rs_ready[e.port], e.data, e.ready);
        end
      end
      @(negedge clk);
    end
    quiet();
  endtask

  task automatic test_scoreboard();
    step_t st[$];
    exp_t e;
    st.push_back(mk(0,0,0,0, 0,0,0,0, 1,9, 9,9, 0,1, 0,1));
    for (int i = 0; i < 3; i++)
      st.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 9,0, 0,0, 0,1));
    st.push_back(mk(0,0,0,0, 1,9,32'h55,1, 0,0, 9,9, 32'h55,1, 32'h55,1));
    st.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 9,9, 32'h55,1, 32'h55,1));
    st.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 9,9, 32'h55,1, 32'h55,1));
    st.push_back(mk(0,0,0,0, 0,0,0,0, 1,10, 10,0, 0,1, 0,1));
    st.push_back(mk(1,10,32'hA0,0, 0,0,0,0, 0,0, 10,0, 32'hA0,0, 0,1));
    st.push_back(mk(1,10,32'hA1,1, 0,0,0,0, 0,0, 10,10, 32'hA1,1, 32'hA1,1));
    st.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 10,10, 32'hA1,1, 32'hA1,1));
    foreach (st[k]) begin
      apply(st[k]);
      #4;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (rs_data[e.port*32 +: 32] !== e.data || rs_ready[e.port] !== e.ready) begin
          miscompares++;
          $display("FAIL scoreboard step%0d port%0d: got data=%h ready=%b want data=%h ready=%b",
                   k, e.port, rs_data[e.port*32 +: 32], rs_ready[e.port], e.data, e.ready);
        end
      end
      @(negedge clk);
    end
    quiet();
  endtask

  task automatic test_set_vs_clear();
    step_t st[$];
    exp_t e;
    st.push_back(mk(0,0,0,0, 1,4,32'h44,1, 1,4, 4,4, 32'h44,1, 32'h44,1));
    st.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 4,4, 32'h44,0, 32'h44,0));
    st.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 4,4, 32'h44,0, 32'h44,0));
    st.push_back(mk(1,4,32'h45,1, 0,0,0,0, 0,0, 4,4, 32'h45,1, 32'h45,1));
    st.push_back(mk(0,0,0,0, 0,0,0,0, 1,11, 11,4, 0,1, 32'h45,1));
    st.push_back(mk(1,11,32'hB0,0, 1,11,32'hB1,1, 0,0, 11,11, 32'hB0,1, 32'hB0,1));
    st.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 11,11, 32'hB0,1, 32'hB0,1));
    foreach (st[k]) begin
      apply(st[k]);
      #4;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (rs_data[e.port*32 +: 32] !== e.data || rs_ready[e.port] !== e.ready) begin
          miscompares++;
          $display("FAIL set_clear step%0d port%0d: got data=%h ready=%b want data=%h ready=%b",
                   k, e.port, rs_data[e.port*32 +: 32], rs_ready[e.port], e.data, e.ready);
        end
      end
      @(negedge clk);
    end
    quiet();
  endtask

  task automatic test_reset_mid_clear();
    step_t st[$];
    exp_t e;
    int cnt;
    apply(mk(1,3,32'h77,0, 0,0,0,0, 1,12, 3,12, 32'h77,1, 0,1));
    exp_q.delete();
    @(negedge clk);
    quiet();
    // start the clear
    clear_req = 1'b1;
    rs_index = {5'd12, 5'd3};
    #4;
    vectors++;
    if (clear_busy !== 1'b0 || rs_data[31:0] !== 32'h77 || rs_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL pre_clear: got busy=%b d0=%h ready=%b want 0 00000077 01",
               clear_busy, rs_data[31:0], rs_ready);
    end
    @(negedge clk);
    clear_req = 1'b0;
    wb0_en = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h99; wb0_clr = 1'b0;
    iss_en = 1'b1; iss_rd = 5'd5;
    for (int k = 1; k <= 9; k++) begin
      #4;
      vectors++;
      if (clear_busy !== 1'b1 || rs_ready !== 2'b00) begin
        miscompares++;
        $display("FAIL mid_clear cycle%0d: got busy=%b ready=%b want 1 00", k, clear_busy, rs_ready);
      end
      if (k == 1) begin
        vectors++;
        if (rs_data[31:0] !== 32'h77) begin
          miscompares++;
          $display("FAIL clear_no_bypass: got %h want 00000077", rs_data[31:0]);
        end
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (clear_busy !== 1'b1 || rs_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_in_clear: got busy=%b ready=%b want 1 00", clear_busy, rs_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      #4;
      if (!clear_busy) break;
      cnt++;
      @(negedge clk);
    end
    quiet();
    vectors++;
    if (cnt != 31) begin
      miscompares++; $display("FAIL restart_clear_cycles: got %0d want 31", cnt);
    end
    @(negedge clk);
    st.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 3,12, 0,1, 0,1));
    st.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 9,5, 0,1, 0,1));
    foreach (st[k]) begin
      apply(st[k]);
      #4;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (rs_data[e.port*32 +: 32] !== e.data || rs_ready[e.port] !== e.ready) begin
          miscompares++;
          $display("FAIL after_restart step%0d port%0d: got data=%h ready=%b want data=%h ready=%b",
                   k, e.port, rs_data[e.port*32 +: 32], rs_ready[e.port], e.data, e.ready);
        end
      end
      @(negedge clk);
    end
    quiet();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    rs_index = '0;
    quiet();
    repeat (3) @(negedge clk);
    test_reset();
    test_write_bypass();
    test_collision();
    test_scoreboard();
    test_set_vs_clear();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised register file for the 5-stage pipeline. It replaces the fixed 32x32, 2-read/1-write file with these additions:
- configurable width, depth and read-port count
- a second write port for the long-latency (load/mul-div) unit
- same-cycle write-to-read bypass
- a per-register busy scoreboard used by the hazard unit
- a hardware clear engine that zeroes the array after reset or on request

Sits between ID (reads and issue marking) and WB/LSU (writes).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >= 4); register 0 is hard-wired zero
NREAD, 2, number of read ports
AW, $clog2(NREGS), index width (derived, not overridable)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
clear_req  in  1  pulse: start the clear engine (ignored while clear_busy)
clear_busy  out  1  clear engine running; all other requests ignored
rs_index  in  NREAD*AW  read indices, port i at [i*AW +: AW]
rs_data  out  NREAD*XLEN  read data, port i at [i*XLEN +: XLEN]
rs_ready  out  NREAD  1 = rs_data[i] is valid architectural data (no pending producer)
wb0_en  in  1  pipeline WB write enable (higher priority)
wb0_rd  in  AW  WB destination
wb0_data  in  XLEN  WB data
wb0_clr  in  1  clear busy[wb0_rd] with this write
wb1_en  in  1  long-latency unit write enable
wb1_rd  in  AW  destination
wb1_data  in  XLEN  data
wb1_clr  in  1  clear busy[wb1_rd] with this write
iss_en  in  1  instruction issued with long-latency destination: mark busy
iss_rd  in  AW  destination to mark busy

Behaviour:
- Reset: asynchronous and active-low (already decided; single clock). While rst_n=0:
  - busy[] = 0
  - state = CLEAR, clear index = 1
  - clear_busy = 1, rs_ready = 0
  - Array contents are not reset asynchronously.
- FSM state IDLE:
  - Writes are taken on the posedge.
  - wb0_en writes wb0_data to wb0_rd; wb1_en writes wb1_data to wb1_rd.
  - If both target the same index, wb0 data wins. A busy clear is still applied if either port's clr is set.
  - Writes to index 0 are dropped. busy[0] is never set.
- FSM state CLEAR:
  - Each cycle writes 0 to reg[idx], then increments idx.
  - The cycle that writes idx=NREGS-1 also moves the FSM to IDLE and clears all busy bits.
  - Duration is exactly NREGS-1 cycles. clear_busy = 1 for the whole state.
  - wb0, wb1, iss and clear_req are ignored. rs_ready = 0.
- IDLE -> CLEAR on clear_req=1 at a posedge. idx restarts at 1, and busy is cleared on entry.
- Reset asserted mid-CLEAR restarts the clear at idx=1.
- Reads are combinational, per port i:
  - index 0 -> data 0, ready 1.
  - Else if wb0 writes that index this cycle -> wb0_data. Else if wb1 writes it -> wb1_data. Else the array value.
  - Bypass is disabled in CLEAR.
- rs_ready[i]: in IDLE, busy[idx] = 0, or a same-cycle write to idx has its clr set. Forced to 0 in CLEAR.
- Scoreboard update on posedge (IDLE only):
  - busy[iss_rd] is set by iss_en (except rd 0).
  - busy[wbN_rd] is cleared by wbN_en & wbN_clr.
  - Set and clear to the same index in the same cycle: set wins, because the new producer supersedes the old one.
- Write latency: 1 cycle to the array. Reads of the written value are same-cycle via bypass.

Decomposition:
- Shared package rf_pkg holds:
  - XLEN_DEF=32, NREGS_DEF=32
  - state enum {RF_IDLE, RF_CLEAR}
  - the helper function for index width
- One natural sub-module: rf_read_port, instantiated NREAD times via generate. It holds the bypass mux and the ready logic for one port.
- The array, scoreboard and FSM stay in regfile_sb.

Test Plan:
- Reset release:
  - Stimulus: rst_n low then high.
  - Required: clear_busy=1 for exactly 31 cycles. Afterwards all regs read 0 and rs_ready=1. Writes issued during clear are not stored.
- Write/read bypass:
  - Stimulus: wb0 writes 0xDEADBEEF to x5 while rs_index port0=5.
  - Required: same-cycle rs_data=0xDEADBEEF; next cycle the array returns 0xDEADBEEF.
- Dual-write collision:
  - Stimulus: wb0 writes x7=0x11 and wb1 writes x7=0x22 in the same cycle.
  - Required: x7 reads 0x11.
  - Stimulus: any write to x0.
  - Required: x0 reads 0.
- Scoreboard:
  - Stimulus: iss x9; then wb1 writes x9=0x55 with clr=1 three cycles later.
  - Required: rs_ready for x9 is 0 for 3 cycles, 1 in the write cycle (bypassed data 0x55), and stays 1 after.
- Set-vs-clear:
  - Stimulus: iss x4 and wb1 clr x4 in the same cycle.
  - Required: busy[4]=1 afterwards.
- Reset mid-clear:
  - Stimulus: clear_req after writing x3=0x77; assert rst_n low at clear cycle 10.
  - Required: the clear restarts and takes the full 31 cycles; x3 ends at 0.
